// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response handshake bundle for muldiv_unit.
//   in_valid/in_ready : request handshake (master -> unit)
//   in_op/in_tag      : operation code and pass-through tag
//   in_a/in_b         : rs1 / rs2 operands
//   out_valid/out_ready : result handshake (unit -> master)
//   out_result/out_tag  : result word and its tag
// The master modport is the issuing pipeline; the slave modport is the unit.
interface muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_tag, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_tag, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous kill of any in-flight or held operation
//   bus   : request/response handshake (muldiv_unit_if slave)
//   busy  : high whenever the unit is not idle
// Multiply retires MUL_STEP multiplier bits per cycle with a shift-add on a
// 2*XLEN accumulator; divide is radix-2 restoring on the same accumulator
// (upper half = partial remainder, lower half = dividend/quotient).
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4,
    parameter int TAG_W    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    muldiv_unit_if.slave  bus,
    output logic          busy
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] N_MUL = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0] N_DIV = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   res_q;

    logic                     accept;
    logic                     is_div;
    logic                     is_rem;
    logic                     sgn_a_op;
    logic                     sgn_b_op;
    logic                     neg_a;
    logic                     neg_b;
    logic [XLEN-1:0]          abs_a;
    logic [XLEN-1:0]          abs_b;
    logic                     div_zero;
    logic                     div_ovf;
    logic [XLEN+MUL_STEP-1:0] partial;
    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [2*XLEN-1:0]        mul_next;
    logic [XLEN:0]            div_shift;
    logic [XLEN:0]            div_diff;
    logic                     div_ge;
    logic [2*XLEN-1:0]        div_next;
    logic [2*XLEN-1:0]        prod;
    logic [XLEN-1:0]          quo;
    logic [XLEN-1:0]          rem;
    logic [XLEN-1:0]          fix_result;

    assign busy           = (state != S_IDLE);
    assign bus.out_valid  = (state == S_DONE);
    assign bus.in_ready   = !flush && ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag_q;
    assign accept         = bus.in_valid && bus.in_ready;

    always_comb begin
        is_div   = op_q[2];
        is_rem   = op_q[2] && op_q[1];
        // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2
        sgn_a_op = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
        sgn_b_op = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
        neg_a    = sgn_a_op && a_q[XLEN-1];
        neg_b    = sgn_b_op && b_q[XLEN-1];
        abs_a    = neg_a ? -a_q : a_q;
        abs_b    = neg_b ? -b_q : b_q;
        div_zero = is_div && (b_q == '0);
        div_ovf  = is_div && !op_q[0] && (a_q == MIN_VAL) && (b_q == '1);

        partial  = {{MUL_STEP{1'b0}}, a_q} * {{XLEN{1'b0}}, acc[MUL_STEP-1:0]};
        mul_sum  = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]} + partial;
        mul_next = {mul_sum, acc[XLEN-1:MUL_STEP]};

        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = !div_diff[XLEN];
        div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};

        prod = (sign_a ^ sign_b) ? -acc : acc;
        quo  = acc[XLEN-1:0];
        rem  = acc[2*XLEN-1:XLEN];
        if (is_div) begin
            if (is_rem) begin
                fix_result = sign_a ? -rem : rem;
            end else begin
                fix_result = (sign_a ^ sign_b) ? -quo : quo;
            end
        end else if (op_q[1:0] == 2'd0) begin
            fix_result = prod[XLEN-1:0];
        end else begin
            fix_result = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            tag_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            res_q  <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) state <= S_PREP;
                end
                S_PREP: begin
                    sign_a <= neg_a;
                    sign_b <= neg_b;
                    if (div_zero) begin
                        res_q <= is_rem ? a_q : '1;
                        state <= S_DONE;
                    end else if (div_ovf) begin
                        res_q <= is_rem ? '0 : a_q;
                        state <= S_DONE;
                    end else begin
                        a_q   <= abs_a;
                        b_q   <= abs_b;
                        acc   <= is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                        cnt   <= is_div ? N_DIV : N_MUL;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    res_q <= fix_result;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) state <= accept ? S_PREP : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Only legal in IDLE or a draining DONE, so never races PREP's writes
            if (accept) begin
                op_q  <= bus.in_op;
                tag_q <= bus.in_tag;
                a_q   <= bus.in_a;
                b_q   <= bus.in_b;
            end
        end
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations for the execute stage. It generalises the fixed 32-bit `alu_muldiv` in four ways: configurable XLEN, configurable multiply radix, full valid/ready handshakes on both input and output with a pass-through tag, and a synchronous flush. Divide-by-zero and signed-overflow cases complete early. It sits beside the single-cycle ALU, and the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 32: operand and result width. Must be 32 or 64.
- `MUL_STEP`, 4: multiplier bits retired per cycle. Allowed values are 1, 2, 4, 8. `XLEN % MUL_STEP == 0`.
- `TAG_W`, 5: tag width (destination register index).

- `clk` in 1: clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous kill of any in-flight or held operation.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `in_op` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in_tag` in TAG_W: returned unchanged with the result.
- `in_a`, `in_b` in XLEN: rs1, rs2.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out XLEN: result.
- `out_tag` out TAG_W: tag of the result.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, PREP, CALC, FIX, DONE.
- **Accept:**
  - An accept happens at an edge where `in_valid && in_ready && !flush`.
  - `in_ready = !flush && (IDLE || (DONE && out_ready))`, so back-to-back issue is allowed in the cycle the result drains.
  - Op, tag and operands are latched at the accept edge. The next state is PREP.
- **PREP (1 cycle):**
  - Record the operand signs per op: MULH signs a and b; MULHSU signs a only; DIV/REM sign both.
  - Take absolute values of signed operands.
  - Detect the special cases:
    - Divide by zero (b == 0): quotient = all-ones; remainder = a.
    - Signed overflow for DIV/REM (a == 1<<(XLEN-1), b == all-ones): quotient = a; remainder = 0.
  - On a special case, go to DONE. Otherwise go to CALC with iteration counter N:
    - N = XLEN/MUL_STEP for MUL ops.
    - N = XLEN for div ops.
- **CALC:**
  - Multiply: each edge adds `MUL_STEP` partial products into a 2·XLEN accumulator.
  - Divide: each edge performs one radix-2 restoring step (1 quotient bit).
  - After N edges, go to FIX.
- **FIX (1 cycle):**
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ.
  - Give the remainder the sign of the dividend.
  - Select the result field: MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - Go to DONE.
- **DONE:**
  - `out_valid = 1`. `out_result` and `out_tag` stay stable until `out_ready`.
  - On `out_ready`: if a new accept occurs, go to PREP; otherwise go to IDLE.
- **`flush`:**
  - From any state, go to IDLE at the next edge. `out_valid` is 0 from that edge.
  - No accept happens in a flush cycle, because `in_ready` is 0.
  - The flushed result is never presented.
- **`rst`:**
  - Forces IDLE immediately, mid-operation included.
  - Outputs during and after reset: `out_valid = 0`, `out_result = 0`, `out_tag = 0`, `busy = 0`.
  - `in_ready = 1`, but no accept occurs while `rst` is high.
- Results are bit-exact to the RISC-V spec for all operand pairs.

## Timing
- Latency is counted from the accept edge E0 to the first edge after which `out_valid` is high.
  - Normal ops: N+2 edges. For XLEN=32: MUL* take 10 at MUL_STEP=4 and 34 at MUL_STEP=1; DIV* take 34.
  - Special divide cases: 1 edge.
- Throughput is one op per latency+1 cycles when `out_ready` is held high. Issue is back-to-back, with no IDLE bubble.
- `out_valid` never drops without either `out_ready` or `flush`.
- `busy` is high from E0 until the edge where the result drains or is flushed.

## Test plan
1. **MUL:** `MUL` 7 × 0xFFFFFFFD (XLEN=32, MUL_STEP=4) → 0xFFFFFFEB, tag echoed, `out_valid` at E0+10.
2. **MULH variants:**
   - `MULH` 0x80000000×0x80000000 → 0x40000000.
   - `MULHSU` 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
   - `MULHU` 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
3. **Signed divide:** `DIV` 0xFFFFFFF9/2 → 0xFFFFFFFD and `REM` → 0xFFFFFFFF at E0+34. `DIVU` 100/7 → 14 and `REMU` → 2.
4. **Special divide cases (latency 1):**
   - `DIVU` 5/0 → 0xFFFFFFFF; `REM` 5/0 → 5.
   - `DIV` 0x80000000/0xFFFFFFFF → 0x80000000; `REM` → 0.
5. **Backpressure:** hold `out_ready` low for 5 cycles after `out_valid`. `out_result`/`out_tag` stay stable and `in_ready` stays 0. Then raise `out_ready` with the next request pending: it is accepted in the same cycle, and its result is correct.
6. **Flush and reset:**
   - Assert `flush` during CALC of a `DIV` at iteration 10. `out_valid` never rises, and `in_ready` = 1 on the next cycle. A following `MUL` 3×4 → 12.
   - Repeat with async `rst` asserted mid-cycle: outputs clear immediately.
   - Rerun the suite at XLEN=64, MUL_STEP=1 against a random reference model (≥10k ops).
